// File: rtl/branch_predict_unit.sv
// Dynamic branch predictor: direct-mapped BTB with saturating direction counters,
// EX-stage resolver and trainer. Optional perf counters under `BPU_PERF_CNT_EN.
module branch_predict_unit #(
  parameter int XLEN     = 32,
  parameter int IDX_BITS = 6,
  parameter int TAG_BITS = 8,
  parameter int CNT_BITS = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic            ex_branch,
  input  logic [1:0]      ex_inst3_2,
  input  logic [2:0]      ex_funct3,
  input  logic            zero_flag,
  input  logic            carry_flag,
  input  logic            overflow_flag,
  input  logic            sign_flag,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic [1:0]      branch_sel,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispredicts
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_LO  = IDX_BITS + 2;
  localparam int TAG_HI  = IDX_BITS + TAG_BITS + 1;
  localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};
  localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_BITS'(1) << (CNT_BITS - 1);
  localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_WT - CNT_BITS'(1);

  logic [ENTRIES-1:0]  tbl_valid;
  logic [TAG_BITS-1:0] tbl_tag    [ENTRIES];
  logic [XLEN-1:0]     tbl_target [ENTRIES];
  logic [CNT_BITS-1:0] tbl_cnt    [ENTRIES];

  logic [IDX_BITS-1:0] if_idx, ex_idx;
  logic [TAG_BITS-1:0] if_tag, ex_tag;
  logic                if_hit, ex_hit;

  assign if_idx = if_pc[IDX_BITS+1:2];
  assign if_tag = if_pc[TAG_HI:TAG_LO];
  assign ex_idx = ex_pc[IDX_BITS+1:2];
  assign ex_tag = ex_pc[TAG_HI:TAG_LO];

  assign if_hit = tbl_valid[if_idx] && (tbl_tag[if_idx] == if_tag);
  assign ex_hit = tbl_valid[ex_idx] && (tbl_tag[ex_idx] == ex_tag);

  // No bypass: a lookup in the same cycle as an update sees the old entry.
  assign pred_taken  = if_hit & tbl_cnt[if_idx][CNT_BITS-1];
  assign pred_target = pred_taken ? tbl_target[if_idx] : if_pc + XLEN'(4);

  logic is_jal, is_jalr, is_jump;
  logic cond_taken, funct3_legal, actual_taken;
  logic ex_live_branch, do_update, alias_clr;

  assign is_jal  = (ex_inst3_2 == 2'b11);
  assign is_jalr = (ex_inst3_2 == 2'b01);
  assign is_jump = is_jal | is_jalr;

  always_comb begin
    cond_taken   = 1'b0;
    funct3_legal = 1'b1;
    case (ex_funct3)
      3'b000:  cond_taken = zero_flag;
      3'b001:  cond_taken = ~zero_flag;
      3'b100:  cond_taken = sign_flag ^ overflow_flag;
      3'b101:  cond_taken = ~(sign_flag ^ overflow_flag);
      3'b110:  cond_taken = ~carry_flag;
      3'b111:  cond_taken = carry_flag;
      default: funct3_legal = 1'b0;
    endcase
  end

  // Jumps ignore funct3 (JAL has immediate bits there), so they are always legal.
  assign actual_taken   = ex_branch & (is_jump | cond_taken);
  assign ex_live_branch = ex_valid & ex_branch;
  assign do_update      = ex_live_branch & (is_jump | funct3_legal);
  assign alias_clr      = ex_valid & ~ex_branch & ex_pred_taken & ex_hit;

  always_comb begin
    branch_sel = 2'b00;
    if (ex_live_branch) begin
      if (is_jalr)           branch_sel = 2'b11;
      else if (actual_taken) branch_sel = 2'b01;
    end
  end

  assign mispredict = ex_valid & (ex_branch
                      ? ((actual_taken != ex_pred_taken) |
                         (actual_taken & (ex_target != ex_pred_target)))
                      : ex_pred_taken);

  assign redirect_pc = actual_taken ? ex_target : ex_pc + XLEN'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_tag[i]    <= '0;
        tbl_target[i] <= '0;
        tbl_cnt[i]    <= CNT_WNT;
      end
    end else if (do_update) begin
      if (ex_hit) begin
        if (actual_taken) begin
          if (tbl_cnt[ex_idx] != CNT_MAX) tbl_cnt[ex_idx] <= tbl_cnt[ex_idx] + CNT_BITS'(1);
          tbl_target[ex_idx] <= ex_target;
        end else if (tbl_cnt[ex_idx] != '0) begin
          tbl_cnt[ex_idx] <= tbl_cnt[ex_idx] - CNT_BITS'(1);
        end
      end else if (actual_taken) begin
        tbl_valid[ex_idx]  <= 1'b1;
        tbl_tag[ex_idx]    <= ex_tag;
        tbl_target[ex_idx] <= ex_target;
        tbl_cnt[ex_idx]    <= CNT_WT;
      end
    end else if (alias_clr) begin
      tbl_valid[ex_idx] <= 1'b0;
    end
  end

`ifdef BPU_PERF_CNT_EN
  logic [31:0] perf_br_q, perf_mp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_br_q <= '0;
      perf_mp_q <= '0;
    end else begin
      if (ex_live_branch) perf_br_q <= perf_br_q + 32'd1;
      if (mispredict)     perf_mp_q <= perf_mp_q + 32'd1;
    end
  end

  assign perf_branches    = perf_br_q;
  assign perf_mispredicts = perf_mp_q;
`else
  assign perf_branches    = '0;
  assign perf_mispredicts = '0;
`endif

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Dynamic branch predictor and resolver for the pipelined RV32 core. At fetch, a direct-mapped branch target buffer (BTB) with saturating direction counters predicts taken/not-taken and the target for the fetch PC. At EX, the unit resolves the actual outcome from ALU flags and funct3, flags mispredictions and supplies the redirect PC. It then trains the table. It generalises the static EX-stage branch selector in table depth, tag width and counter width, and keeps the same `branch_sel` encoding.

## Interface
Parameters:
- `XLEN`, 32, PC/target width
- `IDX_BITS`, 6, log2 of table entries (64)
- `TAG_BITS`, 8, stored tag width
- `CNT_BITS`, 2, direction counter width (≥2)

Ports. One clock; reset is asynchronous and active-low.
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `if_pc`  in  XLEN  fetch PC
- `pred_taken`  out  1  fetch prediction
- `pred_target`  out  XLEN  predicted next PC
- `ex_valid`  in  1  EX stage holds a live instruction
- `ex_branch`  in  1  instruction is branch/jump
- `ex_inst3_2`  in  2  opcode bits [3:2]: 11=JAL, 01=JALR, else conditional
- `ex_funct3`  in  3  branch condition
- `zero_flag`, `carry_flag`, `overflow_flag`, `sign_flag`  in  1 each  ALU flags
- `ex_pc`  in  XLEN  PC of the EX instruction
- `ex_target`  in  XLEN  computed branch/jump target
- `ex_pred_taken`  in  1  prediction carried down the pipe
- `ex_pred_target`  in  XLEN  predicted target carried down the pipe
- `branch_sel`  out  2  00=PC+4, 01=branch/JAL target, 11=JALR
- `mispredict`  out  1  flush IF/ID and redirect
- `redirect_pc`  out  XLEN  correct next PC when `mispredict`=1
- `perf_branches`, `perf_mispredicts`  out  32 each  performance counters

## Operation
- Index = `if_pc[IDX_BITS+1:2]`. Tag = `if_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2]`. Each entry holds valid, tag, target and counter.
- A lookup hits when the entry is valid and its tag matches. `pred_taken` = hit & counter MSB. `pred_target` = stored target when `pred_taken`, else `if_pc+4` (mod 2^XLEN).
- Actual outcome:
  - JAL and JALR are always taken.
  - BEQ: zero. BNE: !zero. BLT: sign≠overflow. BGE: sign==overflow. BLTU: !carry. BGEU: carry.
  - funct3 010/011 resolve as not taken, and the table is not updated.
- `branch_sel` follows the above when `ex_valid & ex_branch`, else 00.
- `mispredict` = `ex_valid` & one of:
  - `ex_branch` & (actual≠`ex_pred_taken` or (actual & `ex_target`≠`ex_pred_target`));
  - !`ex_branch` & `ex_pred_taken` (alias hit on a non-branch).
- `redirect_pc` = `ex_target` if actual taken, else `ex_pc+4`.
- Table update at the clock edge when `ex_valid & ex_branch` with a legal funct3, indexed and tagged by `ex_pc`:
  - Hit: the counter saturating-increments if taken and decrements if not, saturating at 0 and 2^CNT_BITS−1. If taken, the target is written with `ex_target`.
  - Miss and taken: allocate with valid=1, tag, target, and counter = 2^(CNT_BITS−1) (weakly taken).
  - Miss and not taken: no change.
- Alias case (`ex_valid` & !`ex_branch` & `ex_pred_taken` & hit at `ex_pc`): clear that entry's valid bit.

## Timing
- Lookup and resolve are combinational, zero latency. Only table and counter updates are registered.
- An update written at edge N is visible to lookups from cycle N+1. A same-cycle lookup of the same index sees the old contents, with no bypass.
- Reset (async assert, sync release in the surrounding design) sets:
  - every valid bit to 0, every tag and target to 0, every counter to 2^(CNT_BITS−1)−1 (weakly not taken);
  - perf counters to 0.
- While reset is asserted, `pred_taken`=0 and `pred_target`=`if_pc+4`.
- Reset mid-operation discards all training. `mispredict`/`branch_sel` remain purely functions of the EX inputs.
- With `ex_valid`=0: `mispredict`=0, `branch_sel`=00, and no update.

## Configuration
- `BPU_PERF_CNT_EN` defined:
  - `perf_branches` increments on every cycle with `ex_valid & ex_branch`.
  - `perf_mispredicts` increments on every cycle with `mispredict`=1.
  - Both wrap from 0xFFFFFFFF to 0 and both reset to 0.
- Not defined: both ports are tied to 0 and no counter flops exist.

## Test plan
- Reset, then `if_pc`=0x100 → `pred_taken`=0, `pred_target`=0x104.
- BEQ at 0x100, target 0x80, zero=1, `ex_pred_taken`=0 → `mispredict`=1, `redirect_pc`=0x80, `branch_sel`=01. Next cycle, `if_pc`=0x100 → `pred_taken`=1, `pred_target`=0x80.
- Same BEQ resolved not taken twice (zero=0):
  - 1st: `mispredict`=1, `redirect_pc`=0x104, counter 10→01, lookup not taken;
  - 2nd: `mispredict`=0, counter 01→00.
- Five taken resolutions of a hit entry with `CNT_BITS`=2 → counter saturates at 11. One not-taken resolution leaves it at 10, still predicted taken.
- `ex_valid`=1, `ex_branch`=0, `ex_pred_taken`=1 at 0x200 (allocated entry) → `mispredict`=1, `redirect_pc`=0x204. Next cycle the lookup at 0x200 misses.
- With `BPU_PERF_CNT_EN`: 3 branches with 1 mispredict → `perf_branches`=3, `perf_mispredicts`=1. Without the macro, both read 0.
